// File: rtl/lvds_dpa_pkg.sv
// Shared definitions for the LVDS 7:1 receiver DPA training logic.
// Contents:
//   dpa_state_t          training FSM state encoding
//   DEFAULT_TIMEOUT_CYC  default per-attempt DPA timeout in clock cycles
//   DEFAULT_MAX_RETRY    default number of extra attempts per lane
//   idx_width()          bits needed to index a given number of lanes
//   cnt_width()          bits needed to hold a count up to a given value
package lvds_dpa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LRST   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_LINKUP = 3'd5,
    ST_FAIL   = 3'd6
  } dpa_state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 65535;
  localparam int DEFAULT_MAX_RETRY   = 3;

  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/lvds_dpa_timer.sv
// Loadable saturating down-counter used for both the lane-reset hold time
// and the per-attempt DPA timeout.
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset (count cleared)
//   load      load load_val this cycle (wins over en)
//   en        decrement by one; holds at zero instead of wrapping
//   load_val  value to load
//   zero      count is zero
module lvds_dpa_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Down-count register: load has priority, decrement stops at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/lvds_dpa_sequencer.sv
// Link-level training controller for the multi-lane LVDS 7:1 receiver.
// Trains the lanes strictly one after another (lane reset, DPA start pulse,
// wait for DPA done plus byte alignment) with per-lane timeout and retry,
// then reports link-up or training failure with a per-lane fail mask.
// Optional feature macro: ERR_RETRAIN_EN -- retrain a single lane from
// LINKUP after ERR_THRESH consecutive cycles of its I_error_flag.
// Ports:
//   I_clk, I_rst         clock, asynchronous active-high reset
//   I_train_req          rising edge starts full training (ignored while busy)
//   I_lane_dpa_done      per-lane DPA done level
//   I_align_valid        per-lane byte-align valid level
//   I_error_flag         per-lane P/N mismatch flag
//   O_lane_rst           per-lane reset request
//   O_dpa_start          per-lane one-cycle DPA start pulse
//   O_busy               training in progress
//   O_link_up            all lanes trained and aligned
//   O_train_fail         at least one lane exhausted its retries
//   O_fail_mask          per-lane failure of the last training run
module lvds_dpa_sequencer
  import lvds_dpa_pkg::*;
#(
  parameter int LANE_NUM    = 8,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEFAULT_MAX_RETRY,
  parameter int ERR_THRESH  = 256
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_train_req,
  input  logic [LANE_NUM-1:0] I_lane_dpa_done,
  input  logic [LANE_NUM-1:0] I_align_valid,
  input  logic [LANE_NUM-1:0] I_error_flag,
  output logic [LANE_NUM-1:0] O_lane_rst,
  output logic [LANE_NUM-1:0] O_dpa_start,
  output logic                O_busy,
  output logic                O_link_up,
  output logic                O_train_fail,
  output logic [LANE_NUM-1:0] O_fail_mask
);

  localparam int IDX_W = idx_width(LANE_NUM);
  localparam int TMR_W = cnt_width((TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC);
  localparam int RTY_W = cnt_width(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(LANE_NUM - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYC - 1);

  dpa_state_t          state_r;
  logic [IDX_W-1:0]    idx_r;
  logic [RTY_W-1:0]    retry_r;
  logic                req_prev_r;
  logic [LANE_NUM-1:0] lane_rst_r;
  logic [LANE_NUM-1:0] dpa_start_r;
  logic                busy_r;
  logic                link_up_r;
  logic                train_fail_r;
  logic [LANE_NUM-1:0] fail_mask_r;

  logic                tmr_load_s;
  logic                tmr_en_s;
  logic [TMR_W-1:0]    tmr_val_s;
  logic                tmr_zero_s;
  logic                start_s;
  logic                lane_ok_s;
  logic                lanes_ok_s;
  logic                last_lane_s;

  // Requests are honoured only when no training is running
  assign start_s    = I_train_req && !req_prev_r &&
                      ((state_r == ST_IDLE) || (state_r == ST_LINKUP) || (state_r == ST_FAIL));
  assign lane_ok_s  = I_lane_dpa_done[idx_r] && I_align_valid[idx_r];
  assign lanes_ok_s = &(I_lane_dpa_done & I_align_valid);

`ifdef ERR_RETRAIN_EN
  localparam int ERR_W = cnt_width(ERR_THRESH);
  localparam logic [ERR_W-1:0] ERR_TRIG = ERR_W'(ERR_THRESH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(ERR_THRESH);

  logic [ERR_W-1:0]    err_cnt_r [LANE_NUM];
  logic [LANE_NUM-1:0] err_hit_s;
  logic [IDX_W-1:0]    err_idx_s;
  logic                err_any_s;
  logic                single_r;

  // Per-lane run length of consecutive error cycles, only counted while linked
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < LANE_NUM; i++) err_cnt_r[i] <= {ERR_W{1'b0}};
    end else begin
      for (int i = 0; i < LANE_NUM; i++) begin
        if ((state_r == ST_LINKUP) && I_error_flag[i]) begin
          err_cnt_r[i] <= (err_cnt_r[i] == ERR_MAX) ? ERR_MAX : err_cnt_r[i] + ERR_W'(1);
        end else begin
          err_cnt_r[i] <= {ERR_W{1'b0}};
        end
      end
    end
  end

  // A lane trips in the cycle its run length reaches the threshold; lowest index wins
  always_comb begin
    err_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < LANE_NUM; i++) begin
      err_hit_s[i] = (state_r == ST_LINKUP) && I_error_flag[i] && (err_cnt_r[i] >= ERR_TRIG);
    end
    for (int i = LANE_NUM - 1; i >= 0; i--) begin
      err_idx_s = err_hit_s[i] ? IDX_W'(i) : err_idx_s;
    end
    err_any_s = |err_hit_s;
  end

  // A single-lane retrain ends after that lane, wherever it sits
  assign last_lane_s = single_r || (idx_r == LAST_IDX);
`else
  logic err_flag_unused_s;
  assign err_flag_unused_s = ^I_error_flag;
  assign last_lane_s       = (idx_r == LAST_IDX);
`endif

  // Timer control: LRST and WAIT count down; START arms the timeout; a timeout
  // in WAIT re-arms the reset hold for the retry; all other states preload it
  always_comb begin
    tmr_load_s = 1'b1;
    tmr_en_s   = 1'b0;
    tmr_val_s  = RST_LOAD;
    case (state_r)
      ST_LRST: begin
        tmr_load_s = 1'b0;
        tmr_en_s   = 1'b1;
      end
      ST_START: tmr_val_s = TMO_LOAD;
      ST_WAIT: begin
        tmr_load_s = tmr_zero_s;
        tmr_en_s   = 1'b1;
      end
      default: tmr_load_s = 1'b1;
    endcase
  end

  lvds_dpa_timer #(.W(TMR_W)) u_timer (
    .clk      (I_clk),
    .rst      (I_rst),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Training FSM with all outputs registered
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      retry_r      <= {RTY_W{1'b0}};
      req_prev_r   <= 1'b0;
      lane_rst_r   <= {LANE_NUM{1'b1}};
      dpa_start_r  <= {LANE_NUM{1'b0}};
      busy_r       <= 1'b0;
      link_up_r    <= 1'b0;
      train_fail_r <= 1'b0;
      fail_mask_r  <= {LANE_NUM{1'b0}};
`ifdef ERR_RETRAIN_EN
      single_r     <= 1'b0;
`endif
    end else begin
      req_prev_r  <= I_train_req;
      dpa_start_r <= {LANE_NUM{1'b0}};
      if (start_s) begin
        // Full run: every lane goes back into reset until its turn
        state_r      <= ST_LRST;
        idx_r        <= {IDX_W{1'b0}};
        retry_r      <= {RTY_W{1'b0}};
        lane_rst_r   <= {LANE_NUM{1'b1}};
        busy_r       <= 1'b1;
        link_up_r    <= 1'b0;
        train_fail_r <= 1'b0;
        fail_mask_r  <= {LANE_NUM{1'b0}};
`ifdef ERR_RETRAIN_EN
        single_r     <= 1'b0;
`endif
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_LRST: begin
            if (tmr_zero_s) begin
              lane_rst_r[idx_r] <= 1'b0;
              state_r           <= ST_START;
            end else begin
              lane_rst_r[idx_r] <= 1'b1;
            end
          end
          ST_START: begin
            dpa_start_r[idx_r] <= 1'b1;
            state_r            <= ST_WAIT;
          end
          ST_WAIT: begin
            // Success is tested first so it wins a same-cycle timeout
            if (lane_ok_s) begin
              state_r <= ST_NEXT;
            end else if (tmr_zero_s) begin
              lane_rst_r[idx_r] <= 1'b1;
              if (retry_r < RETRY_LIMIT) begin
                retry_r <= retry_r + RTY_W'(1);
                state_r <= ST_LRST;
              end else begin
                fail_mask_r[idx_r] <= 1'b1;
                state_r            <= ST_NEXT;
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end
          ST_NEXT: begin
            retry_r <= {RTY_W{1'b0}};
            if (last_lane_s) begin
`ifdef ERR_RETRAIN_EN
              single_r <= 1'b0;
`endif
              busy_r <= 1'b0;
              if (fail_mask_r != {LANE_NUM{1'b0}}) begin
                train_fail_r <= 1'b1;
                state_r      <= ST_FAIL;
              end else begin
                link_up_r <= 1'b1;
                state_r   <= ST_LINKUP;
              end
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= ST_LRST;
            end
          end
          ST_LINKUP: begin
            if (!lanes_ok_s) begin
              link_up_r <= 1'b0;
              state_r   <= ST_IDLE;
`ifdef ERR_RETRAIN_EN
            end else if (err_any_s) begin
              link_up_r             <= 1'b0;
              busy_r                <= 1'b1;
              idx_r                 <= err_idx_s;
              retry_r               <= {RTY_W{1'b0}};
              single_r              <= 1'b1;
              lane_rst_r[err_idx_s] <= 1'b1;
              state_r               <= ST_LRST;
`endif
            end else begin
              state_r <= ST_LINKUP;
            end
          end
          ST_FAIL: state_r <= ST_FAIL;
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign O_lane_rst   = lane_rst_r;
  assign O_dpa_start  = dpa_start_r;
  assign O_busy       = busy_r;
  assign O_link_up    = link_up_r;
  assign O_train_fail = train_fail_r;
  assign O_fail_mask  = fail_mask_r;

endmodule

// File: tb/tb_lvds_dpa_sequencer.sv
// Self-checking bench for lvds_dpa_sequencer. Expected DPA start pulses are
// queued when a training request is issued and popped as the DUT emits them.
module tb_lvds_dpa_sequencer;

  localparam int LN         = 8;
  localparam int RST_CYC    = 16;
  localparam int TMO        = 200;
  localparam int MAX_RETRY  = 3;
  localparam int ERR_THRESH = 256;
  localparam int GAP        = TMO + RST_CYC + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          train_req;
  logic [LN-1:0] lane_dpa_done;
  logic [LN-1:0] align_valid;
  logic [LN-1:0] error_flag;
  logic [LN-1:0] lane_rst;
  logic [LN-1:0] dpa_start;
  logic          busy;
  logic          link_up;
  logic          train_fail;
  logic [LN-1:0] fail_mask;

  int check_cnt = 0;
  int err_cnt   = 0;
  int cyc       = 0;
  int t0        = 0;
  int up_cyc    = 0;
  logic link_prev = 1'b0;

  int exp_q[$];
  int plog_lane[$];
  int plog_cyc[$];

  int            delay_cfg [LN];
  bit            never_cfg [LN];
  int            rem       [LN];
  bit            armed     [LN];
  int            done_cyc  [LN];
  logic [LN-1:0] up   = '0;
  logic [LN-1:0] kill = '0;

  assign lane_dpa_done = up;
  assign align_valid   = up & ~kill;

  lvds_dpa_sequencer #(
    .LANE_NUM    (LN),
    .RST_CYC     (RST_CYC),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (MAX_RETRY),
    .ERR_THRESH  (ERR_THRESH)
  ) dut (
    .I_clk           (clk),
    .I_rst           (rst),
    .I_train_req     (train_req),
    .I_lane_dpa_done (lane_dpa_done),
    .I_align_valid   (align_valid),
    .I_error_flag    (error_flag),
    .O_lane_rst      (lane_rst),
    .O_dpa_start     (dpa_start),
    .O_busy          (busy),
    .O_link_up       (link_up),
    .O_train_fail    (train_fail),
    .O_fail_mask     (fail_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Lane model: done+valid rise delay_cfg cycles after the start pulse; reset clears it
  always @(negedge clk) begin
    for (int i = 0; i < LN; i++) begin
      if (rst || lane_rst[i]) begin
        up[i] = 1'b0; armed[i] = 1'b0; rem[i] = 0;
      end else if (dpa_start[i]) begin
        up[i] = 1'b0; rem[i] = delay_cfg[i]; armed[i] = !never_cfg[i];
      end else if (armed[i]) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) begin
          up[i] = 1'b1; armed[i] = 1'b0; done_cyc[i] = cyc;
        end
      end
    end
  end

  // Scoreboard side: compare every start pulse with the queued expectation
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (dpa_start != '0) begin
        if (exp_q.size() == 0) begin
          check("start_unexpected", 32'(dpa_start), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("start_lane", 32'(dpa_start), 32'h1 << e);
        end
        for (int i = 0; i < LN; i++) begin
          if (dpa_start[i]) begin
            plog_lane.push_back(i);
            plog_cyc.push_back(cyc);
          end
        end
      end
      if (link_up && !link_prev) up_cyc = cyc;
    end
    link_prev = link_up;
  end

  task automatic set_delays(input int d);
    for (int i = 0; i < LN; i++) begin
      delay_cfg[i] = d;
      never_cfg[i] = 1'b0;
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(i);
  endtask

  task automatic request();
    plog_lane.delete();
    plog_cyc.delete();
    @(negedge clk);
    train_req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    train_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(link_up || train_fail) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lane_rst"},   32'(lane_rst),   32'hFF);
    check({tag, "_dpa_start"},  32'(dpa_start),  32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
    check({tag, "_link_up"},    32'(link_up),    32'h0);
    check({tag, "_train_fail"}, 32'(train_fail), 32'h0);
    check({tag, "_fail_mask"},  32'(fail_mask),  32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n3;
    int prev3;
    int n;
    rst = 1'b1; train_req = 1'b0; error_flag = '0;
    set_delays(100);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Normal run: all lanes respond 100 cycles after their start pulse
    push_range(0, 7);
    request();
    check("busy_after_req", 32'(busy), 32'd1);
    wait_done(5000);
    @(negedge clk);
    check("t1_link_up",    32'(link_up),    32'd1);
    check("t1_train_fail", 32'(train_fail), 32'd0);
    check("t1_fail_mask",  32'(fail_mask),  32'h0);
    check("t1_busy",       32'(busy),       32'd0);
    check("t1_lane_rst",   32'(lane_rst),   32'h0);
    check("t1_sb_empty",   32'(exp_q.size()), 32'd0);
    check("t1_first_start_latency", 32'(plog_cyc[0] - t0), 32'(RST_CYC + 2));
    check("t1_linkup_latency", 32'(up_cyc - done_cyc[7]), 32'd2);

    // Align drop on lane 1 while linked
    kill[1] = 1'b1;
    @(negedge clk);
    check("drop_link_up", 32'(link_up), 32'd0);
    kill[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("drop_idle_link_up", 32'(link_up), 32'd0);
    check("drop_idle_busy",    32'(busy),    32'd0);

    // Lane 3 never completes: four attempts, then lanes 4..7
    never_cfg[3] = 1'b1;
    push_range(0, 3); push_range(3, 3); push_range(3, 3); push_range(3, 3); push_range(4, 7);
    request();
    wait_done(8000);
    @(negedge clk);
    check("t2_train_fail", 32'(train_fail), 32'd1);
    check("t2_fail_mask",  32'(fail_mask),  32'h08);
    check("t2_link_up",    32'(link_up),    32'd0);
    check("t2_busy",       32'(busy),       32'd0);
    check("t2_lane_rst",   32'(lane_rst),   32'h08);
    check("t2_sb_empty",   32'(exp_q.size()), 32'd0);
    n3 = 0; prev3 = 0;
    foreach (plog_lane[k]) begin
      if (plog_lane[k] == 3) begin
        if (n3 > 0) check("t2_lane3_gap", 32'(plog_cyc[k] - prev3), 32'(GAP));
        prev3 = plog_cyc[k];
        n3++;
      end
    end
    check("t2_lane3_starts", 32'(n3), 32'd4);

    // Lane 2 completes exactly when its timeout reaches zero
    never_cfg[3] = 1'b0;
    delay_cfg[2] = TMO;
    push_range(0, 7);
    request();
    check("t3_fail_cleared", 32'(train_fail), 32'd0);
    wait_done(5000);
    @(negedge clk);
    check("t3_link_up",   32'(link_up),   32'd1);
    check("t3_fail_mask", 32'(fail_mask), 32'h0);
    check("t3_sb_empty",  32'(exp_q.size()), 32'd0);
    check("t3_starts",    32'(plog_lane.size()), 32'd8);

    // One cycle too late on lane 2: every attempt times out
    delay_cfg[2] = TMO + 1;
    push_range(0, 2); push_range(2, 2); push_range(2, 2); push_range(2, 2); push_range(3, 7);
    request();
    wait_done(8000);
    @(negedge clk);
    check("t3b_train_fail", 32'(train_fail), 32'd1);
    check("t3b_fail_mask",  32'(fail_mask),  32'h04);
    check("t3b_lane_rst",   32'(lane_rst),   32'h04);
    check("t3b_sb_empty",   32'(exp_q.size()), 32'd0);

    // Reset while waiting on lane 5, then a clean restart from lane 0
    delay_cfg[2] = 100;
    push_range(0, 5);
    request();
    n = 0;
    while (plog_lane.size() < 6 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_lane5", 32'(n < 5000), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("t4_async_reset");
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_range(0, 7);
    request();
    wait_done(5000);
    @(negedge clk);
    check("t4_link_up",     32'(link_up),      32'd1);
    check("t4_first_lane",  32'(plog_lane[0]), 32'd0);
    check("t4_sb_empty2",   32'(exp_q.size()), 32'd0);

    plog_lane.delete();
    plog_cyc.delete();
`ifdef ERR_RETRAIN_EN
    // 255 consecutive error cycles on lane 6 must not trigger anything
    error_flag[6] = 1'b1;
    repeat (ERR_THRESH - 1) @(negedge clk);
    error_flag[6] = 1'b0;
    repeat (20) @(negedge clk);
    check("err255_link_up", 32'(link_up), 32'd1);
    check("err255_starts",  32'(plog_lane.size()), 32'd0);

    // 256 consecutive cycles retrain lane 6 alone
    push_range(6, 6);
    error_flag[6] = 1'b1;
    repeat (ERR_THRESH - 1) @(negedge clk);
    check("err256_before", 32'(link_up), 32'd1);
    @(negedge clk);
    check("err256_link_drop", 32'(link_up), 32'd0);
    check("err256_busy",      32'(busy),    32'd1);
    error_flag[6] = 1'b0;
    wait_done(3000);
    @(negedge clk);
    check("err256_link_up",   32'(link_up),   32'd1);
    check("err256_fail_mask", 32'(fail_mask), 32'h0);
    check("err256_starts",    32'(plog_lane.size()), 32'd1);
    check("err256_sb_empty",  32'(exp_q.size()), 32'd0);
`else
    // Error flags have no effect when retraining on errors is not built
    error_flag = '1;
    repeat (300) @(negedge clk);
    error_flag = '0;
    check("errflag_link_up", 32'(link_up), 32'd1);
    check("errflag_busy",    32'(busy),    32'd0);
    check("errflag_starts",  32'(plog_lane.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
